// File: rtl/sweep_acq_multi_if.sv
// Ready/valid output stream of the sweep acquisition top: point headers followed by buffered ACQ words.
interface sweep_acq_multi_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] SweepACQData;
    logic                  SweepACQData_en;
    logic                  SweepACQData_ready;

    modport master (
        output SweepACQData,
        output SweepACQData_en,
        input  SweepACQData_ready
    );

    modport slave (
        input  SweepACQData,
        input  SweepACQData_en,
        output SweepACQData_ready
    );
endinterface

// File: rtl/sweep_acq_multi.sv
// Multi-DAC threshold sweep: per point reload the ASIC, acquire MaxPackageNumber words into a local
// FIFO, then stream a two-word header and the buffered words through a ready/valid port.
module sweep_acq_multi #(
    parameter int DAC_WIDTH  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int NUM_DAC    = 3,
    parameter int FIFO_DEPTH = 128,
    localparam int SEL_W     = (NUM_DAC > 1) ? $clog2(NUM_DAC) : 1
) (
    input  logic                         Clk,
    input  logic                         reset_n,
    input  logic                         SweepStart,
    input  logic                         SweepStop,
    input  logic [SEL_W-1:0]             DACSelect,
    input  logic [DAC_WIDTH-1:0]         StartDAC,
    input  logic [DAC_WIDTH-1:0]         EndDAC,
    input  logic [DAC_WIDTH-1:0]         StepDAC,
    input  logic [CNT_WIDTH-1:0]         MaxPackageNumber,
    input  logic [DATA_WIDTH-1:0]        ParallelData,
    input  logic                         ParallelData_en,
    input  logic                         MicrorocConfigDone,
    output logic [NUM_DAC*DAC_WIDTH-1:0] OutDAC,
    output logic                         LoadSCParameter,
    output logic                         SingleACQStart,
    sweep_acq_multi_if.master            outBus,
    output logic                         Busy,
    output logic                         ACQDone,
    output logic                         Overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_CFG, ACQ, HDR0, HDR1, DRAIN, STEP, DONE
    } state_t;

    state_t state, nextState;

    logic                  startSync_p0, startSync_p1, startSync_p2;
    logic                  startEdge;
    logic [SEL_W-1:0]      selLat;
    logic [DAC_WIDTH-1:0]  codeCur, endLat, stepLat;
    logic                  dirDown;
    logic [CNT_WIDTH-1:0]  maxLat, pkgCnt, pkgCntNext;
    logic [DAC_WIDTH:0]    stepNext;
    logic                  stepDone;
    logic [AW:0]           wrPtr, rdPtr;
    logic [DATA_WIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic                  fifoEmpty, fifoFull, fifoWr, fifoRd;
    logic                  abortReq;
    logic [DATA_WIDTH-1:0] hdrWord;

    // One extra bit carries the wrap/borrow so range escapes are visible.
    function automatic logic [DAC_WIDTH:0] advanceCode(input logic [DAC_WIDTH-1:0] code,
                                                       input logic [DAC_WIDTH-1:0] step,
                                                       input logic down);
        if (down) return {1'b0, code} - {1'b0, step};
        else      return {1'b0, code} + {1'b0, step};
    endfunction

    function automatic logic pastEnd(input logic [DAC_WIDTH:0] nxt,
                                     input logic [DAC_WIDTH-1:0] last,
                                     input logic down);
        if (nxt[DAC_WIDTH]) return 1'b1;
        if (down) return nxt[DAC_WIDTH-1:0] < last;
        else      return nxt[DAC_WIDTH-1:0] > last;
    endfunction

    assign startEdge  = startSync_p1 & ~startSync_p2;
    assign abortReq   = SweepStop & (state != IDLE);
    assign pkgCntNext = pkgCnt + CNT_WIDTH'(1);
    assign stepNext   = advanceCode(codeCur, stepLat, dirDown);
    assign stepDone   = pastEnd(stepNext, endLat, dirDown);
    assign fifoEmpty  = (wrPtr == rdPtr);
    assign fifoFull   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign fifoWr     = (state == ACQ) && ParallelData_en && !fifoFull;
    assign fifoRd     = (state == DRAIN) && !fifoEmpty && outBus.SweepACQData_ready;
    assign hdrWord    = DATA_WIDTH'(codeCur) | (DATA_WIDTH'(4'(selLat)) << (DATA_WIDTH - 4));

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (startEdge) nextState = LOAD;
            LOAD:     nextState = WAIT_CFG;
            WAIT_CFG: if (MicrorocConfigDone) nextState = (maxLat == '0) ? HDR0 : ACQ;
            ACQ:      if (ParallelData_en && (pkgCntNext == maxLat)) nextState = HDR0;
            HDR0:     if (outBus.SweepACQData_ready) nextState = HDR1;
            HDR1:     if (outBus.SweepACQData_ready) nextState = DRAIN;
            DRAIN:    if (fifoEmpty) nextState = STEP;
            STEP:     nextState = stepDone ? DONE : LOAD;
            DONE:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
        if (abortReq) nextState = IDLE;
    end

    // FWFT read: the word at the read pointer is presented while DRAIN has data.
    always_comb begin
        outBus.SweepACQData_en = 1'b0;
        outBus.SweepACQData    = '0;
        case (state)
            HDR0: begin
                outBus.SweepACQData_en = 1'b1;
                outBus.SweepACQData    = DATA_WIDTH'(16'h5A5A);
            end
            HDR1: begin
                outBus.SweepACQData_en = 1'b1;
                outBus.SweepACQData    = hdrWord;
            end
            DRAIN: begin
                outBus.SweepACQData_en = !fifoEmpty;
                if (!fifoEmpty) outBus.SweepACQData = fifoMem[rdPtr[AW-1:0]];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (fifoWr) fifoMem[wrPtr[AW-1:0]] <= ParallelData;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            startSync_p0    <= 1'b0;
            startSync_p1    <= 1'b0;
            startSync_p2    <= 1'b0;
            selLat          <= '0;
            codeCur         <= '0;
            endLat          <= '0;
            stepLat         <= '0;
            dirDown         <= 1'b0;
            maxLat          <= '0;
            pkgCnt          <= '0;
            wrPtr           <= '0;
            rdPtr           <= '0;
            OutDAC          <= '0;
            LoadSCParameter <= 1'b0;
            SingleACQStart  <= 1'b0;
            Busy            <= 1'b0;
            ACQDone         <= 1'b0;
            Overflow        <= 1'b0;
        end else begin
            state           <= nextState;
            startSync_p0    <= SweepStart;
            startSync_p1    <= startSync_p0;
            startSync_p2    <= startSync_p1;
            LoadSCParameter <= (state == LOAD) && !abortReq;
            SingleACQStart  <= (state == WAIT_CFG) && (nextState == ACQ);
            ACQDone         <= (state == DONE) && !abortReq;
            Busy            <= (nextState != IDLE);

            if ((state == IDLE) && startEdge) begin
                selLat   <= DACSelect;
                codeCur  <= StartDAC;
                endLat   <= EndDAC;
                stepLat  <= (StepDAC == '0) ? DAC_WIDTH'(1) : StepDAC;
                dirDown  <= (StartDAC > EndDAC);
                maxLat   <= MaxPackageNumber;
                Overflow <= 1'b0;
            end

            if (state == LOAD) begin
                pkgCnt <= '0;
                for (int i = 0; i < NUM_DAC; i++) begin
                    if (selLat == SEL_W'(i)) OutDAC[i*DAC_WIDTH +: DAC_WIDTH] <= codeCur;
                end
            end

            // Dropped words still count so a point always terminates.
            if ((state == ACQ) && ParallelData_en) begin
                pkgCnt <= pkgCntNext;
                if (fifoFull) Overflow <= 1'b1;
            end

            if ((state == STEP) && !stepDone) codeCur <= stepNext[DAC_WIDTH-1:0];

            if (abortReq) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (fifoWr) wrPtr <= wrPtr + (AW+1)'(1);
                if (fifoRd) rdPtr <= rdPtr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_sweep_acq_multi.sv
// Randomised bench for sweep_acq_multi: a point-list reference model predicts the full output stream.
`timescale 1ns/1ps
module tb_sweep_acq_multi;

    localparam int DAC_WIDTH  = 10;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 16;
    localparam int NUM_DAC    = 3;
    localparam int FIFO_DEPTH = 128;
    localparam int SEL_W      = 2;

    logic                         Clk = 1'b0;
    logic                         reset_n = 1'b0;
    logic                         SweepStart = 1'b0, SweepStop = 1'b0;
    logic [SEL_W-1:0]             DACSelect = '0;
    logic [DAC_WIDTH-1:0]         StartDAC = '0, EndDAC = '0, StepDAC = '0;
    logic [CNT_WIDTH-1:0]         MaxPackageNumber = '0;
    logic [DATA_WIDTH-1:0]        ParallelData = '0;
    logic                         ParallelData_en = 1'b0;
    logic                         MicrorocConfigDone = 1'b0;
    logic [NUM_DAC*DAC_WIDTH-1:0] OutDAC;
    logic                         LoadSCParameter, SingleACQStart, Busy, ACQDone, Overflow;
    logic                         readyDrv = 1'b1;

    sweep_acq_multi_if #(.DATA_WIDTH(DATA_WIDTH)) outBus ();
    assign outBus.SweepACQData_ready = readyDrv;

    sweep_acq_multi #(
        .DAC_WIDTH(DAC_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH),
        .NUM_DAC(NUM_DAC), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Clk(Clk), .reset_n(reset_n),
        .SweepStart(SweepStart), .SweepStop(SweepStop), .DACSelect(DACSelect),
        .StartDAC(StartDAC), .EndDAC(EndDAC), .StepDAC(StepDAC),
        .MaxPackageNumber(MaxPackageNumber),
        .ParallelData(ParallelData), .ParallelData_en(ParallelData_en),
        .MicrorocConfigDone(MicrorocConfigDone),
        .OutDAC(OutDAC), .LoadSCParameter(LoadSCParameter), .SingleACQStart(SingleACQStart),
        .outBus(outBus),
        .Busy(Busy), .ACQDone(ACQDone), .Overflow(Overflow)
    );

    initial forever #5 Clk = ~Clk;

    int checks = 0, failures = 0;
    int pts[$];
    logic [15:0] expQ[$], dataQ[$], obsQ[$];
    int modelDac[NUM_DAC];
    int loadCnt, sasCnt, doneCnt, loadIdx;
    int curSel = 0, curMax = 0, readyMode = 0;
    bit acqActive = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_DAC*DAC_WIDTH-1:0] packDac();
        logic [NUM_DAC*DAC_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DAC; i++) v[i*DAC_WIDTH +: DAC_WIDTH] = DAC_WIDTH'(modelDac[i]);
        return v;
    endfunction

    // Point list and complete output stream derived from the sweep rules with plain integers.
    task automatic buildModel(input int sel, input int st, input int en, input int stp, input int mx);
        int s;
        logic [15:0] d;
        s = (stp == 0) ? 1 : stp;
        pts.delete(); expQ.delete(); dataQ.delete();
        if (st <= en) for (int c = st; c <= en; c += s) pts.push_back(c);
        else          for (int c = st; c >= en; c -= s) pts.push_back(c);
        foreach (pts[k]) begin
            expQ.push_back(16'h5A5A);
            expQ.push_back(16'((sel << 12) | pts[k]));
            for (int w = 0; w < mx; w++) begin
                d = 16'($urandom);
                dataQ.push_back(d);
                if (w < FIFO_DEPTH) expQ.push_back(d);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (LoadSCParameter) begin
                repeat (3) @(negedge Clk);
                MicrorocConfigDone = 1'b1;
                @(negedge Clk);
                MicrorocConfigDone = 1'b0;
            end
        end
    end

    // ACQ source: MaxPackageNumber words with random gaps, then two stray strobes.
    initial begin
        forever begin
            @(negedge Clk);
            if (SingleACQStart) begin
                acqActive = 1'b1;
                for (int w = 0; w < curMax + 2; w++) begin
                    repeat ($urandom_range(0, 2)) @(negedge Clk);
                    if (w < curMax && dataQ.size() > 0) ParallelData = dataQ.pop_front();
                    else ParallelData = 16'hDEAD;
                    ParallelData_en = 1'b1;
                    @(negedge Clk);
                    ParallelData_en = 1'b0;
                end
                acqActive = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            case (readyMode)
                0:       readyDrv = 1'b1;
                1:       readyDrv = ~readyDrv;
                default: readyDrv = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: stream words, handshake stability, OutDAC on each load, event counts.
    initial begin
        logic prevEn, prevRdy, prevStop;
        logic [15:0] prevData;
        prevEn = 1'b0; prevRdy = 1'b0; prevStop = 1'b0; prevData = '0;
        forever begin
            @(negedge Clk);
            if (reset_n) begin
                if (prevEn && !prevRdy && !prevStop) begin
                    check("hold_en", 64'(outBus.SweepACQData_en), 64'd1);
                    check("hold_data", 64'(outBus.SweepACQData), 64'(prevData));
                end
                if (outBus.SweepACQData_en && readyDrv) begin
                    obsQ.push_back(outBus.SweepACQData);
                    if (expQ.size() == 0) check("word_expected", 64'(expQ.size()), 64'd1);
                    else check("out_word", 64'(outBus.SweepACQData), 64'(expQ.pop_front()));
                end
                if (LoadSCParameter) begin
                    loadCnt++;
                    if (loadIdx < pts.size()) modelDac[curSel] = pts[loadIdx];
                    loadIdx++;
                    check("outdac", 64'(OutDAC), 64'(packDac()));
                end
                if (SingleACQStart) sasCnt++;
                if (ACQDone) doneCnt++;
            end
            prevEn = outBus.SweepACQData_en; prevRdy = readyDrv;
            prevStop = SweepStop; prevData = outBus.SweepACQData;
        end
    end

    // mode 0: run to completion, 1: abort during 2nd point, 2: reset during 1st point
    task automatic runSweep(input int sel, input int st, input int en, input int stp,
                            input int mx, input int rmode, input int mode);
        for (int i = 0; i < 2000 && acqActive; i++) @(negedge Clk);
        check("src_idle", 64'(acqActive), 64'd0);
        buildModel(sel, st, en, stp, mx);
        curSel = sel; curMax = mx; readyMode = rmode;
        loadCnt = 0; sasCnt = 0; doneCnt = 0; loadIdx = 0; obsQ.delete();
        @(negedge Clk);
        DACSelect = SEL_W'(sel); StartDAC = DAC_WIDTH'(st); EndDAC = DAC_WIDTH'(en);
        StepDAC = DAC_WIDTH'(stp); MaxPackageNumber = CNT_WIDTH'(mx); SweepStart = 1'b1;
        for (int i = 0; i < 20 && !Busy; i++) @(negedge Clk);
        check("busy_rise", 64'(Busy), 64'd1);
        check("overflow_cleared", 64'(Overflow), 64'd0);
        SweepStart = 1'b0;
        if (mode == 1) begin
            for (int i = 0; i < 5000 && sasCnt < 2; i++) @(negedge Clk);
            check("abort_reach_pt2", 64'(sasCnt >= 2), 64'd1);
            repeat (2) @(negedge Clk);
            @(posedge Clk); #1 SweepStop = 1'b1;
            @(posedge Clk); #1;
            check("abort_busy", 64'(Busy), 64'd0);
            check("abort_en", 64'(outBus.SweepACQData_en), 64'd0);
            SweepStop = 1'b0;
            repeat (20) @(negedge Clk);
            check("abort_no_done", 64'(doneCnt), 64'd0);
            check("abort_left", 64'(expQ.size()), 64'((pts.size() - 1) * (2 + mx)));
        end else if (mode == 2) begin
            for (int i = 0; i < 5000 && sasCnt < 1; i++) @(negedge Clk);
            repeat (3) @(negedge Clk);
            @(posedge Clk); #1 reset_n = 1'b0;
            #1;
            check("rst_busy", 64'(Busy), 64'd0);
            check("rst_outdac", 64'(OutDAC), 64'd0);
            check("rst_en", 64'(outBus.SweepACQData_en), 64'd0);
            check("rst_load", 64'(LoadSCParameter), 64'd0);
            for (int i = 0; i < NUM_DAC; i++) modelDac[i] = 0;
            for (int i = 0; i < 2000 && acqActive; i++) @(negedge Clk);
            @(negedge Clk);
            reset_n = 1'b1;
            repeat (5) @(negedge Clk);
            check("rst_stay_idle", 64'(Busy), 64'd0);
        end else begin
            for (int i = 0; i < 20000 && doneCnt == 0; i++) @(negedge Clk);
            repeat (5) @(negedge Clk);
            check("done_once", 64'(doneCnt), 64'd1);
            check("stream_complete", 64'(expQ.size()), 64'd0);
            check("load_count", 64'(loadCnt), 64'(pts.size()));
            check("acq_start_count", 64'(sasCnt), 64'((mx == 0) ? 0 : pts.size()));
            check("overflow", 64'(Overflow), 64'(mx > FIFO_DEPTH));
            check("busy_end", 64'(Busy), 64'd0);
        end
        expQ.delete();
    endtask

    initial begin
        int st, en;
        for (int i = 0; i < NUM_DAC; i++) modelDac[i] = 0;
        repeat (3) @(negedge Clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_en", 64'(outBus.SweepACQData_en), 64'd0);
        check("reset_data", 64'(outBus.SweepACQData), 64'd0);
        check("reset_load", 64'(LoadSCParameter), 64'd0);
        check("reset_acqstart", 64'(SingleACQStart), 64'd0);
        check("reset_done", 64'(ACQDone), 64'd0);
        check("reset_overflow", 64'(Overflow), 64'd0);
        check("reset_outdac", 64'(OutDAC), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        runSweep(1, 100, 103, 1, 4, 0, 0);
        check("up_words", 64'(obsQ.size()), 64'd24);
        check("up_hdr0", 64'(obsQ[0]), 64'h5A5A);
        check("up_hdr1", 64'(obsQ[1]), 64'h1064);
        check("up_pt2_hdr1", 64'(obsQ[13]), 64'h1066);
        check("up_outdac", 64'(OutDAC), 64'({10'd0, 10'd103, 10'd0}));

        runSweep(0, 50, 40, 4, 3, 0, 0);
        check("down_points", 64'(pts.size()), 64'd3);
        check("down_last", 64'(pts[2]), 64'd42);
        check("down_hdr1", 64'(obsQ[1]), 64'h0032);
        check("down_outdac", 64'(OutDAC[9:0]), 64'd42);

        runSweep(1, 100, 103, 1, 4, 1, 0);
        check("bp_words", 64'(obsQ.size()), 64'd24);

        runSweep(2, 300, 300, 1, 130, 0, 0);
        check("ovf_words", 64'(obsQ.size()), 64'd130);

        runSweep(0, 10, 20, 1, 20, 2, 1);
        runSweep(0, 10, 12, 1, 3, 0, 0);
        check("restart_hdr1", 64'(obsQ[1]), 64'h000A);

        runSweep(2, 5, 8, 0, 2, 2, 0);
        check("step0_points", 64'(pts.size()), 64'd4);

        runSweep(1, 200, 210, 3, 0, 0, 0);
        check("max0_words", 64'(obsQ.size()), 64'd8);

        runSweep(0, 1023, 1023, 5, 1, 0, 0);
        check("top_points", 64'(pts.size()), 64'd1);
        check("top_outdac", 64'(OutDAC[9:0]), 64'd1023);

        for (int r = 0; r < 6; r++) begin
            st = $urandom_range(0, 1023);
            en = st + $urandom_range(0, 30) - 15;
            if (en < 0) en = 0;
            if (en > 1023) en = 1023;
            runSweep($urandom_range(0, 2), st, en, $urandom_range(0, 5),
                     $urandom_range(0, 8), $urandom_range(0, 2), 0);
        end

        runSweep(1, 500, 505, 1, 10, 0, 2);
        runSweep(2, 7, 3, 2, 5, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sweep_acq_multi.md
Name: sweep_acq_multi

Overview:
- Parametrised successor to the single-DAC sweep acquisition top for the Microroc SC/ACQ chain.
- Steps any one of NUM_DAC threshold DACs from a start code to an end code, up or down, by a programmable step.
- At each point it reconfigures the ASIC, runs one acquisition of MaxPackageNumber words, buffers them internally, then emits a two-word point header followed by the buffered data through a ready/valid output.
- Adds abort, step size, descending sweeps, overflow flagging and output backpressure.

Parameters:
- DAC_WIDTH, 10, DAC code width.
- DATA_WIDTH, 16, ACQ/output word width; must be >= DAC_WIDTH+4.
- CNT_WIDTH, 16, package counter width.
- NUM_DAC, 3, number of selectable DACs (max 16).
- FIFO_DEPTH, 128, per-point buffer depth in words; power of 2.

Ports:
- Clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- SweepStart  in  1  level; the rising edge is detected internally after a 2-flop register.
- SweepStop  in  1  level; abort request.
- DACSelect  in  clog2(NUM_DAC)  index of the DAC to sweep; latched at start.
- StartDAC  in  DAC_WIDTH  first code.
- EndDAC  in  DAC_WIDTH  last code (inclusive bound).
- StepDAC  in  DAC_WIDTH  step magnitude; 0 is treated as 1.
- MaxPackageNumber  in  CNT_WIDTH  words per point.
- ParallelData  in  DATA_WIDTH  ACQ word.
- ParallelData_en  in  1  ACQ word strobe.
- MicrorocConfigDone  in  1  SC load complete (level or pulse).
- OutDAC  out  NUM_DAC*DAC_WIDTH  per-DAC codes; only the selected slice changes.
- LoadSCParameter  out  1  one-cycle SC load pulse.
- SingleACQStart  out  1  one-cycle acquisition start pulse.
- SweepACQData  out  DATA_WIDTH  output word.
- SweepACQData_en  out  1  output valid.
- SweepACQData_ready  in  1  downstream ready.
- Busy  out  1  high from start until DONE or abort.
- ACQDone  out  1  one-cycle pulse at normal completion.
- Overflow  out  1  sticky; cleared at the next start.

Behaviour:
- Reset: all outputs 0, OutDAC 0, FIFO empty, state IDLE.
- Parameters are latched on the cycle the start edge is seen in IDLE. Start edges outside IDLE are ignored.
- Direction is down if StartDAC > EndDAC, otherwise up.
- States and transitions:
  - IDLE → LOAD on start edge.
  - LOAD: OutDAC slice ← current code; LoadSCParameter pulses 1 cycle; → WAIT_CFG.
  - WAIT_CFG: on MicrorocConfigDone=1, SingleACQStart pulses 1 cycle; → ACQ. If MaxPackageNumber=0, go directly to HDR0 with no SingleACQStart.
  - ACQ: each ParallelData_en increments the counter and writes the FIFO. When counter = MaxPackageNumber → HDR0. Strobes arriving after that are ignored.
  - HDR0: word 16'h5A5A (DATA_WIDTH-sized, zero-extended).
  - HDR1: word {DACSelect in 4 bits, zero pad, current code}.
  - DRAIN: FIFO words in order until empty.
  - STEP: next = code ± step, computed DAC_WIDTH+1 wide. If it passes EndDAC, or under/overflows the range, → DONE. Otherwise code ← next → LOAD.
  - DONE: ACQDone pulse, Busy←0 → IDLE.
- The last point is exactly EndDAC only when reachable by whole steps. Codes never exceed EndDAC in the sweep direction.
- Output handshake:
  - A word transfers when SweepACQData_en & SweepACQData_ready are both high.
  - Data and en hold stable while ready=0.
  - FIFO read is first-word-fall-through; no bubble between consecutive words when ready is held high.
  - Header and data words share the same handshake.
- FIFO full while in ACQ: the word is dropped, Overflow←1, and the counter still increments so the point still terminates.
- SweepStop=1 in any non-IDLE state:
  - Next cycle → IDLE, FIFO flushed, Busy←0, no ACQDone.
  - SweepACQData_en drops even mid-transfer.
  - OutDAC keeps its last value.
- Reset mid-operation: immediate return to reset values.

Test Plan:
- Up sweep: sel=1, Start=100, End=103, Step=1, Max=4, ready=1, ConfigDone 3 cycles after each Load → 4 LoadSCParameter pulses. OutDAC[19:10] takes 100..103. 24 output words: each point is 5A5A, {1,code}, then 4 data words. One ACQDone pulse; OutDAC[9:0] and [29:20] stay 0.
- Down sweep with coarse step: Start=50, End=40, Step=4 → points 50, 46, 42 only (38 < 40 is excluded); 3 headers seen.
- Backpressure: ready toggled 1/0 every cycle during DRAIN → word order and values identical to the ready=1 run; en/data held during ready=0.
- Overflow: FIFO_DEPTH=128, Max=130 → 128 data words out for the point, Overflow=1. Next start clears Overflow.
- Abort: SweepStop asserted during ACQ of the second point → Busy falls within 1 cycle, no ACQDone, FIFO empty. A new start then restarts cleanly from StartDAC.
- Edge cases: Step=0 behaves as 1; Max=0 produces header-only points with no SingleACQStart; Start=End=1023, Step=5 → exactly one point, no wrap.
